// File: rtl/ascii_entry_ctrl.sv
// Keypad/terminal entry controller: collects ASCII decimal digits from the UART,
// converts them to binary one digit per cycle and hands the value to a consumer.
module ascii_entry_ctrl #(
  parameter int DIGITS  = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_rx_dv,
  input  logic [7:0]       i_rx_byte,
  input  logic             i_ack,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_value,
  output logic             o_valid,
  output logic             o_err,
  output logic [2:0]       o_err_code,
  output logic [3:0]       o_digit_cnt,
  output logic             o_echo_dv,
  output logic [7:0]       o_echo_byte,
  output logic [2:0]       o_dbg_state
);

  localparam int BW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [3:0]    MAX_CNT  = 4'(DIGITS);

  localparam logic [2:0] ERR_OVERFLOW = 3'd1;
  localparam logic [2:0] ERR_EMPTY    = 3'd2;
  localparam logic [2:0] ERR_BADCHAR  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_ABORT    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CONVERT = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    buf_q, buf_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [2:0]       code_q, code_d;
  logic             echo_dv_q, echo_dv_d;
  logic [7:0]       echo_byte_q, echo_byte_d;

  logic       is_digit;
  logic [3:0] cur_digit;

  assign is_digit  = (i_rx_byte >= 8'h30) && (i_rx_byte <= 8'h39);
  // Nibble 0 holds the most recent digit, so the first-typed digit sits at idx cnt-1.
  assign cur_digit = 4'(buf_q >> {idx_q, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      code_q      <= '0;
      echo_dv_q   <= 1'b0;
      echo_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      code_q      <= code_d;
      echo_dv_q   <= echo_dv_d;
      echo_byte_q <= echo_byte_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    code_d      = code_q;
    echo_dv_d   = 1'b0;
    echo_byte_d = echo_byte_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_COLLECT;
          buf_d   = '0;
          cnt_d   = '0;
          acc_d   = '0;
          tmo_d   = '0;
          code_d  = '0;
        end
      end

      S_COLLECT: begin
        if (i_rx_dv) begin
          tmo_d = '0;
          if (is_digit) begin
            if (cnt_q < MAX_CNT) begin
              buf_d       = (buf_q << 4) | BW'(i_rx_byte[3:0]);
              cnt_d       = cnt_q + 4'd1;
              echo_dv_d   = 1'b1;
              echo_byte_d = i_rx_byte;
            end else begin
              state_d = S_ERROR;
              code_d  = ERR_OVERFLOW;
            end
          end else begin
            case (i_rx_byte)
              8'h08: begin
                if (cnt_q != 4'd0) begin
                  buf_d       = buf_q >> 4;
                  cnt_d       = cnt_q - 4'd1;
                  echo_dv_d   = 1'b1;
                  echo_byte_d = i_rx_byte;
                end
              end
              8'h0D: begin
                if (cnt_q != 4'd0) begin
                  state_d = S_CONVERT;
                  acc_d   = '0;
                  idx_d   = IW'(cnt_q - 4'd1);
                end else begin
                  state_d = S_ERROR;
                  code_d  = ERR_EMPTY;
                end
              end
              8'h1B: begin
                state_d = S_ERROR;
                code_d  = ERR_ABORT;
              end
              default: begin
                state_d = S_ERROR;
                code_d  = ERR_BADCHAR;
              end
            endcase
          end
        end else if ((TIMEOUT > 0) && (tmo_q == TMO_LAST)) begin
          state_d = S_ERROR;
          code_d  = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_CONVERT: begin
        acc_d = (acc_q << 3) + (acc_q << 1) + WIDTH'(cur_digit);
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      // o_valid is a level held from entry to DONE until i_ack is sampled high;
      // the transfer completes on that edge and o_valid drops the next cycle.
      S_DONE: begin
        if (i_ack) begin
          state_d = S_IDLE;
        end
      end

      S_ERROR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_value     = acc_q;
  assign o_valid     = (state_q == S_DONE);
  assign o_err       = (state_q == S_ERROR);
  assign o_err_code  = code_q;
  assign o_digit_cnt = cnt_q;
  assign o_echo_dv   = echo_dv_q;
  assign o_echo_byte = echo_byte_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ascii_entry_ctrl.sv
// Bench for ascii_entry_ctrl: directed entry scenarios followed by randomized
// sessions, every cycle compared against a transaction-level reference model.
module tb_ascii_entry_ctrl;

  localparam int DIGITS  = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 100;

  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_CONVERT = 2;
  localparam int M_DONE    = 3;
  localparam int M_ERROR   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic             i_rx_dv;
  logic [7:0]       i_rx_byte;
  logic             i_ack;
  logic             o_busy;
  logic [WIDTH-1:0] o_value;
  logic             o_valid;
  logic             o_err;
  logic [2:0]       o_err_code;
  logic [3:0]       o_digit_cnt;
  logic             o_echo_dv;
  logic [7:0]       o_echo_byte;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int         m_mode;
  int         m_digits[$];
  int         m_code;
  int         m_idle;
  int         m_left;
  bit         m_echo_dv;
  logic [7:0] m_echo_byte;
  longint     m_val;
  bit         m_known;

  ascii_entry_ctrl #(.DIGITS(DIGITS), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rx_dv(i_rx_dv),
    .i_rx_byte(i_rx_byte), .i_ack(i_ack), .o_busy(o_busy), .o_value(o_value),
    .o_valid(o_valid), .o_err(o_err), .o_err_code(o_err_code),
    .o_digit_cnt(o_digit_cnt), .o_echo_dv(o_echo_dv), .o_echo_byte(o_echo_byte),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint decimal_value();
    longint v = 0;
    foreach (m_digits[i]) v = (v * 10 + m_digits[i]) % (longint'(1) << WIDTH);
    return v;
  endfunction

  task automatic raise(input int code);
    m_mode = M_ERROR;
    m_code = code;
  endtask

  // Applies the entry rules to the inputs present at the coming edge.
  task automatic model_edge();
    m_echo_dv = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_digits.delete(); m_code = 0; m_idle = 0; m_left = 0;
      m_echo_byte = 8'h00; m_val = 0; m_known = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: if (i_start) begin
          m_mode = M_COLLECT; m_digits.delete(); m_code = 0; m_idle = 0;
          m_val = 0; m_known = 1'b1;
        end
        M_COLLECT: begin
          if (i_rx_dv) begin
            m_idle = 0;
            if (i_rx_byte >= 8'h30 && i_rx_byte <= 8'h39) begin
              if (m_digits.size() < DIGITS) begin
                m_digits.push_back(int'(i_rx_byte) - 48);
                m_echo_dv = 1'b1; m_echo_byte = i_rx_byte;
              end else raise(1);
            end else if (i_rx_byte == 8'h08) begin
              if (m_digits.size() > 0) begin
                void'(m_digits.pop_back());
                m_echo_dv = 1'b1; m_echo_byte = i_rx_byte;
              end
            end else if (i_rx_byte == 8'h0D) begin
              if (m_digits.size() > 0) begin
                m_mode = M_CONVERT; m_left = m_digits.size();
                m_val = decimal_value(); m_known = 1'b0;
              end else raise(2);
            end else if (i_rx_byte == 8'h1B) raise(5);
            else raise(3);
          end else begin
            m_idle++;
            if (TIMEOUT > 0 && m_idle >= TIMEOUT) raise(4);
          end
        end
        M_CONVERT: begin
          m_left--;
          if (m_left == 0) begin m_mode = M_DONE; m_known = 1'b1; end
        end
        M_DONE: if (i_ack) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic compare();
    check("busy", o_busy, m_mode != M_IDLE);
    check("valid", o_valid, m_mode == M_DONE);
    check("err", o_err, m_mode == M_ERROR);
    check("err_code", o_err_code, m_code);
    check("digit_cnt", o_digit_cnt, m_digits.size());
    check("echo_dv", o_echo_dv, m_echo_dv);
    check("echo_byte", o_echo_byte, m_echo_byte);
    if (m_known) check("value", o_value, m_val[WIDTH-1:0]);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_dv = 1'b1; i_rx_byte = b;
    cycle();
    i_rx_dv = 1'b0;
  endtask

  task automatic start();
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
  endtask

  task automatic ack();
    i_ack = 1'b1;
    cycle();
    i_ack = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    if (r < 60) return 8'h30 + 8'($urandom_range(0, 9));
    if (r < 72) return 8'h08;
    if (r < 82) return 8'h0D;
    if (r < 86) return 8'h1B;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic idle_rand();
    i_ack   = ($urandom_range(0, 7) == 0);
    i_start = ($urandom_range(0, 19) == 0);
    rst     = ($urandom_range(0, 99) == 0);
    cycle();
    i_ack = 1'b0; i_start = 1'b0; rst = 1'b0;
  endtask

  task automatic drain_rand();
    for (int k = 0; k < 60 && m_mode != M_IDLE; k++) begin
      i_ack     = ($urandom_range(0, 2) == 0);
      i_rx_dv   = ($urandom_range(0, 3) == 0);
      i_rx_byte = rand_byte();
      cycle();
      i_ack = 1'b0; i_rx_dv = 1'b0;
    end
    check("drain_busy", o_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_rx_dv = 1'b0; i_rx_byte = 8'h00; i_ack = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_busy", o_busy, 1'b0);
    check("rst_value", o_value, 0);
    check("rst_echo_byte", o_echo_byte, 8'h00);

    // 1037 entry with echoes and handshake
    start();
    check("start_busy", o_busy, 1'b1);
    send(8'h31); check("echo_1", o_echo_byte, 8'h31);
    send(8'h30); check("echo_0", o_echo_byte, 8'h30);
    send(8'h33); check("echo_3", o_echo_byte, 8'h33);
    send(8'h37); check("echo_7", o_echo_byte, 8'h37); check("echo_7_dv", o_echo_dv, 1'b1);
    send(8'h0D);
    idle(3); check("conv_not_valid", o_valid, 1'b0);
    idle(1); check("valid_1037", o_valid, 1'b1); check("value_1037", o_value, 1037);
    send(8'h35); check("done_ignore_byte", o_value, 1037);
    idle(2); check("done_hold_valid", o_valid, 1'b1);
    ack();
    check("ack_busy", o_busy, 1'b0); check("ack_valid", o_valid, 1'b0);
    check("ack_value_hold", o_value, 1037);

    // backspace editing
    start();
    send(8'h31); check("cnt_a", o_digit_cnt, 4'd1);
    send(8'h32); check("cnt_b", o_digit_cnt, 4'd2);
    send(8'h08); check("cnt_c", o_digit_cnt, 4'd1); check("bs_echo", o_echo_byte, 8'h08);
    send(8'h35); check("cnt_d", o_digit_cnt, 4'd2);
    send(8'h0D);
    idle(2); check("value_15", o_value, 15); check("valid_15", o_valid, 1'b1);
    ack();

    // empty backspace, then abort
    start();
    send(8'h08); check("bs_empty_echo", o_echo_dv, 1'b0); check("bs_empty_cnt", o_digit_cnt, 4'd0);
    send(8'h1B); check("esc_err", o_err, 1'b1); check("esc_code", o_err_code, 3'd5);
    idle(1); check("esc_busy", o_busy, 1'b0);

    // overflow, empty CR, bad char
    start();
    repeat (4) send(8'h39);
    send(8'h31); check("ovf_err", o_err, 1'b1); check("ovf_code", o_err_code, 3'd1);
    idle(1); check("ovf_busy", o_busy, 1'b0);
    start(); check("code_cleared", o_err_code, 3'd0);
    send(8'h0D); check("empty_code", o_err_code, 3'd2);
    idle(1); check("empty_busy", o_busy, 1'b0);
    start();
    send(8'h41); check("bad_err", o_err, 1'b1); check("bad_code", o_err_code, 3'd3);
    idle(1); check("bad_busy", o_busy, 1'b0);

    // timeout and the strobe that races it
    start();
    send(8'h34);
    idle(99); check("tmo_pending", o_err, 1'b0);
    idle(1); check("tmo_err", o_err, 1'b1); check("tmo_code", o_err_code, 3'd4);
    idle(1); check("tmo_busy", o_busy, 1'b0);
    start();
    send(8'h34);
    idle(99);
    send(8'h35); check("race_no_err", o_err, 1'b0); check("race_cnt", o_digit_cnt, 4'd2);
    send(8'h1B);
    idle(1);

    // reset during CONVERT, stray byte in IDLE, restart
    start();
    send(8'h38); send(8'h38); send(8'h0D);
    idle(1);
    apply_reset();
    check("mid_rst_busy", o_busy, 1'b0); check("mid_rst_cnt", o_digit_cnt, 4'd0);
    check("mid_rst_value", o_value, 0);
    send(8'h35); check("idle_byte_busy", o_busy, 1'b0); check("idle_byte_echo", o_echo_dv, 1'b0);
    start(); send(8'h35); send(8'h0D);
    idle(1); check("value_5", o_value, 5); check("valid_5", o_valid, 1'b1);
    ack();

    // start and byte together in IDLE
    i_start = 1'b1; i_rx_dv = 1'b1; i_rx_byte = 8'h37;
    cycle();
    i_start = 1'b0; i_rx_dv = 1'b0;
    check("start_dv_cnt", o_digit_cnt, 4'd0); check("start_dv_echo", o_echo_dv, 1'b0);
    send(8'h1B);
    idle(1);

    // randomized sessions
    for (int s = 0; s < 150; s++) begin
      int n;
      i_start = 1'b1;
      if ($urandom_range(0, 9) == 0) begin i_rx_dv = 1'b1; i_rx_byte = rand_byte(); end
      cycle();
      i_start = 1'b0; i_rx_dv = 1'b0;
      n = $urandom_range(0, 7);
      for (int k = 0; k < n; k++) begin
        int gap;
        send(rand_byte());
        gap = ($urandom_range(0, 29) == 0) ? $urandom_range(98, 102) : $urandom_range(0, 2);
        repeat (gap) idle_rand();
      end
      if (m_mode == M_COLLECT) send(8'h0D);
      drain_rand();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ascii_entry_ctrl.md
# ascii_entry_ctrl

Sequencing controller for numeric keypad/terminal entry in the CryptoATM datapath. Sits behind the UART receiver. It is armed by the transaction FSM and collects ASCII decimal digits from the RX byte strobe, handling backspace, abort and timeout. On carriage return it serially converts the buffered digits to binary. It then presents the value to the consumer (PIN check, amount entry) with a valid/ack handshake and echoes accepted characters for the terminal.

## Interface
- DIGITS, 4, maximum digits accepted (1..8)
- WIDTH, 16, output value width; must hold 10^DIGITS-1
- TIMEOUT, 0, idle cycles in COLLECT before timeout error; 0 disables
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  arm a new entry; honoured only in IDLE
- i_rx_dv  in  1  one-cycle strobe, i_rx_byte valid
- i_rx_byte  in  8  received ASCII byte
- i_ack  in  1  consumer accepts o_value
- o_busy  out  1  high in any state except IDLE
- o_value  out  WIDTH  converted binary value, valid while o_valid
- o_valid  out  1  level, held until i_ack
- o_err  out  1  one-cycle error pulse
- o_err_code  out  3  last error: 0 none, 1 overflow, 2 empty, 3 bad char, 4 timeout, 5 abort
- o_digit_cnt  out  4  digits currently buffered
- o_echo_dv  out  1  one-cycle echo strobe
- o_echo_byte  out  8  byte to echo

## Operation
- States: IDLE, COLLECT, CONVERT, DONE, ERROR.
- IDLE: i_rx_dv ignored. i_start -> COLLECT. Entering COLLECT clears the digit buffer, count, accumulator, timeout counter and o_err_code.
- Digit buffer: DIGITS BCD nibbles. A new digit shifts in at nibble 0; backspace shifts right and zero-fills the top nibble.
- COLLECT, on i_rx_dv:
  - 0x30..0x39 with cnt<DIGITS: store byte-0x30, cnt+1, echo.
  - 0x30..0x39 with cnt==DIGITS: ERROR, code 1.
  - 0x08 with cnt>0: drop last digit, cnt-1, echo. With cnt==0: ignored, no echo.
  - 0x0D with cnt>0: CONVERT. With cnt==0: ERROR, code 2.
  - 0x1B: ERROR, code 5.
  - Any other byte: ERROR, code 3.
- Timeout: counter resets on entry to COLLECT and on every i_rx_dv. When it reaches TIMEOUT (TIMEOUT>0): ERROR, code 4. An i_rx_dv in the same cycle wins over the timeout.
- CONVERT: acc starts at 0. One step per cycle for i=cnt-1 down to 0: acc <= (acc<<3)+(acc<<1)+digit[i], truncated to WIDTH. After cnt steps -> DONE.
- DONE: o_value=acc, o_valid=1. i_ack -> IDLE; o_valid drops and o_value holds its last value.
- ERROR: o_err pulses 1 cycle; o_err_code latched (held until next start or rst); -> IDLE next cycle.
- i_rx_dv in CONVERT, DONE and ERROR is ignored. i_start outside IDLE is ignored. i_start and i_rx_dv together in IDLE: the byte is dropped.
- rst in any state: IDLE next edge, all registers cleared, any in-flight entry discarded.

## Timing
- Reset values: o_busy 0, o_value 0, o_valid 0, o_err 0, o_err_code 0, o_digit_cnt 0, o_echo_dv 0, o_echo_byte 0.
- i_start at edge T: o_busy=1 from T+1.
- Digit or backspace accepted at edge T: o_digit_cnt updates and o_echo_dv/o_echo_byte assert at T+1 for one cycle.
- CR accepted at edge T: CONVERT occupies T+1..T+cnt; o_valid=1 from T+cnt+1.
- i_ack sampled high while o_valid: o_valid=0 and o_busy=0 next cycle. i_ack outside DONE is ignored.
- Error event at edge T: o_err=1 during T+1 only; o_busy=0 from T+2.
- Back-to-back i_rx_dv every cycle is supported in COLLECT.

## Test plan
- Reset then i_start; send '1','0','3','7',CR -> echoes 0x31,0x30,0x33,0x37; o_valid 5 cycles after CR with o_value=1037; i_ack -> o_busy=0.
- '1','2',BS,'5',CR -> o_digit_cnt 1,2,1,2; o_value=15. BS with empty buffer -> no echo, count stays 0.
- DIGITS=4: '9','9','9','9','1' -> o_err pulse, o_err_code=1. CR alone -> code 2. 'A' (0x41) -> code 3. ESC -> code 5. After each, o_busy=0.
- TIMEOUT=100: i_start, '4', then 100 idle cycles -> o_err_code=4. Strobe arriving on the timeout cycle is accepted instead.
- rst asserted mid-CONVERT after '8','8',CR -> all outputs 0 next cycle. Then '5' with no i_start -> ignored; i_start, '5',CR -> o_value=5.
- i_start and i_rx_dv('7') together in IDLE -> byte dropped, cnt=0. Bytes during DONE -> ignored, o_value stable until i_ack.
